// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter with a small TX FIFO.
//
// Bytes are accepted on a valid/ready port, held in a FIFO_DEPTH-entry FIFO
// and shifted out on an idle-high serial line: one start bit (0), eight data
// bits LSB first, one stop bit (1). Each bit lasts CPB = CLK_FREQ_HZ/BAUD_RATE
// clocks, so a frame is exactly 10*CPB clocks. When another byte is waiting
// at the end of a stop bit, the next start bit follows with no idle gap.
//
// Ports
//   clk         in   core clock
//   rst         in   synchronous, active-high reset (aborts any frame)
//   in_valid    in   byte offered
//   in_ready    out  FIFO can accept (not full)
//   in_data     in   byte to send, sampled only on a push
//   tx          out  serial line, registered, idle high
//   busy        out  frame in progress or FIFO non-empty
//   fifo_level  out  current FIFO occupancy
// ---------------------------------------------------------------------------

package uart_pkg;

    typedef enum int unsigned {
        BR_9600   = 9600,
        BR_19200  = 19200,
        BR_38400  = 38400,
        BR_57600  = 57600,
        BR_115200 = 115200
    } uart_baud_rate_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned     CLK_FREQ_HZ = 100_000_000,
    parameter uart_baud_rate_t BAUD_RATE   = BR_115200,
    parameter int unsigned     FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CPB   = CLK_FREQ_HZ / int'(BAUD_RATE);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
        end
        if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
            $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers. Pointers carry one extra wrap bit so that
    // full and empty are told apart by the MSB alone.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Serializer state
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;
    logic             tx_q;
    logic             tx_n;
    logic             cnt_last;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready depends only on registered pointers, so a pop in the same cycle
    // never opens room for a push into a full FIFO.
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign fifo_level = wr_ptr - rd_ptr;

    assign busy     = (state != IDLE) || !empty;
    assign tx       = tx_q;
    assign cnt_last = (baud_cnt == CNT_LAST);

    // FIFO data array: written on push only, never reset (pointers define
    // which entries are valid).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // State register. tx is registered here; the next-state logic computes
    // the line level for the state being entered so tx changes on the same
    // edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx_q;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_n    = mem[rd_ptr[AW-1:0]];
                    baud_cnt_n = '0;
                    state_n    = START;
                    tx_n       = 1'b0;
                end
            end

            START: begin
                tx_n = 1'b0;
                if (cnt_last) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                    tx_n       = shift[0];
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                tx_n = shift[0];
                if (cnt_last) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        // Next bit becomes shift[0]; drive it now so it
                        // appears on tx at the bit boundary.
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (cnt_last) begin
                    baud_cnt_n = '0;
                    if (!empty) begin
                        // Back-to-back frame: start bit follows immediately.
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr[AW-1:0]];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule
